// File: rtl/display_7seg_mux.sv
// display_7seg_mux: time-multiplexed driver for N common-anode 7-segment digits.
// A prescaler divides the enabled clock into digit slots. Each slot starts with
// a few all-anodes-off guard cycles to suppress ghosting. A shadow copy of the
// BCD value and the decimal-point mask is taken once per frame, so each scan
// shows a single coherent number. All display outputs are registered.
module display_7seg_mux #(
  parameter int N        = 3,
  parameter int DIV      = 50000,
  parameter int GUARD    = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic [N*4-1:0] bcd,
  input  logic [N-1:0]   dp_mask,
  output logic [N-1:0]   an,
  output logic [6:0]     seg,
  output logic           dp,
  output logic           frame_done
);

  // Counter widths: the prescaler must hold DIV-1 and the index must hold N-1.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] GUARD_C  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX  = IW'(N - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  // Codes 10..15 are not valid BCD and are shown as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Scan state
  logic [PW-1:0]  r_pcnt;
  logic [IW-1:0]  r_idx;
  logic [N*4-1:0] r_shd;
  logic [N-1:0]   r_shd_dp;
  logic           r_frame_done;

  // Registered display outputs
  logic [N-1:0]   r_an;
  logic [6:0]     r_seg;
  logic           r_dp;

  // Combinational helpers
  logic           w_tick;
  logic           w_wrap;
  logic           w_guard;
  logic [N-1:0]   w_lz;
  logic [3:0]     w_digit;
  logic           w_dp_sel;
  logic           w_blank_sel;
  logic [N-1:0]   w_an_slot;
  logic [6:0]     w_seg_slot;

  // A slot ends on the last prescaler count of an enabled cycle; the frame ends
  // when that happens on the last digit.
  assign w_tick  = clk_en && (r_pcnt == PCNT_MAX);
  assign w_wrap  = w_tick && (r_idx == IDX_MAX);
  assign w_guard = (r_pcnt < GUARD_C);

  // Leading-zero chain: w_lz[i] is set when shadow digits i..N-1 are all zero
  // and none of them has its decimal point lit.
  always_comb begin
    w_lz = '0;
    w_lz[N-1] = (r_shd[N*4-1 -: 4] == 4'd0) && !r_shd_dp[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (r_shd[i*4 +: 4] == 4'd0) && !r_shd_dp[i];
    end
  end

  // Select the shadow digit, its decimal point, its blanking state and its
  // anode for the slot currently being scanned.
  always_comb begin
    w_digit     = 4'd0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_an_slot   = '1;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit      = r_shd[i*4 +: 4];
        w_dp_sel     = r_shd_dp[i];
        w_blank_sel  = (BLANK_LZ != 0) && (i != 0) && w_lz[i];
        w_an_slot[i] = 1'b0;
      end else begin
        w_an_slot[i] = 1'b1;
      end
    end
  end

  // Segment pattern for the active slot; a blanked digit keeps its anode on
  // but lights nothing.
  always_comb begin
    w_seg_slot = SEG_OFF;
    if (w_blank_sel) begin
      w_seg_slot = SEG_OFF;
    end else begin
      w_seg_slot = seg_decode(w_digit);
    end
  end

  // Prescaler, digit index, per-frame shadow capture and end-of-frame pulse.
  // Everything holds while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_shd        <= '0;
      r_shd_dp     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_pcnt <= '0;
        if (r_idx == IDX_MAX) begin
          r_idx    <= '0;
          r_shd    <= bcd;
          r_shd_dp <= dp_mask;
        end else begin
          r_idx    <= r_idx + IW'(1);
        end
      end else if (clk_en) begin
        r_pcnt <= r_pcnt + PW'(1);
      end else begin
        r_pcnt <= r_pcnt;
      end
    end
  end

  // Output register: one cycle behind the scan state. All anodes are off
  // during guard cycles so the segment change never shows on a neighbour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (w_guard) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_slot;
      r_seg <= w_seg_slot;
      r_dp  <= ~w_dp_sel;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_7seg_mux.sv
// Bench for display_7seg_mux with N=3, DIV=4, GUARD=1, BLANK_LZ=1.
// One frame is 12 cycles: 3 slots, each 1 guard cycle plus 3 display cycles.
// Expected per-cycle outputs are queued as stimulus is applied and compared
// on the falling edge.
module tb_display_7seg_mux;

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [11:0] bcd;
  logic [2:0]  dp_mask;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  exp_t sb_q[$];
  int   n_checks;
  int   n_pass;

  display_7seg_mux #(
    .N(3), .DIV(4), .GUARD(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bcd(bcd), .dp_mask(dp_mask),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Queue frame entries lo..hi. Entry 4*s is the guard cycle of slot s; the
  // next three show code cs with anode s low. frame_done rides on entry 11.
  task automatic push_frame(input logic [6:0] c0, input logic [6:0] c1,
                            input logic [6:0] c2, input logic [2:0] m,
                            input int lo, input int hi);
    logic [6:0] codes [3];
    exp_t       e;
    logic [2:0] one_hot;
    int         s;
    codes[0] = c0;
    codes[1] = c1;
    codes[2] = c2;
    for (int k = lo; k <= hi; k++) begin
      s = k / 4;
      if ((k % 4) == 0) begin
        e.an  = 3'b111;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = 1'b0;
      end else begin
        one_hot = 3'b001 << s;
        e.an  = ~one_hot;
        e.seg = codes[s];
        e.dp  = ~m[s];
        e.fd  = (k == 11);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    clk_en  = 1'b1;
    bcd     = 12'h105;
    dp_mask = 3'b000;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({an, seg, dp, frame_done} !== {3'b111, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset: got an=%b seg=%h dp=%b fd=%b, want an=111 seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    else n_pass++;
  endtask

  // First frame after reset shows shadow zeros; 105 appears after frame_done.
  task automatic test_scan;
    exp_t e;
    #2 rst = 1'b1;
    push_frame(7'h40, 7'h7F, 7'h7F, 3'b000, 0, 11);
    push_frame(7'h12, 7'h40, 7'h79, 3'b000, 0, 11);
    push_frame(7'h12, 7'h40, 7'h79, 3'b000, 0, 11);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) $display("FAIL scan[%0d]: scoreboard empty", k);
      else begin
        e = sb_q.pop_front();
        if ({an, seg, dp, frame_done} !== e)
          $display("FAIL scan[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                   k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        else n_pass++;
      end
    end
  endtask

  // 007 blanks digits 1 and 2; a lit dp on digit 2 un-blanks digits 1 and 2.
  task automatic test_blanking;
    exp_t e;
    bcd = 12'h007;
    push_frame(7'h12, 7'h40, 7'h79, 3'b000, 0, 11);
    push_frame(7'h78, 7'h7F, 7'h7F, 3'b000, 0, 11);
    push_frame(7'h78, 7'h40, 7'h40, 3'b100, 0, 11);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) $display("FAIL blank[%0d]: scoreboard empty", k);
      else begin
        e = sb_q.pop_front();
        if ({an, seg, dp, frame_done} !== e)
          $display("FAIL blank[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                   k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        else n_pass++;
      end
      if (k == 11) dp_mask = 3'b100;
    end
  endtask

  // A mid-frame input change must not tear the frame being shown.
  task automatic test_back_to_back;
    exp_t e;
    bcd     = 12'h199;
    dp_mask = 3'b000;
    push_frame(7'h78, 7'h40, 7'h40, 3'b100, 0, 11);
    push_frame(7'h10, 7'h10, 7'h79, 3'b000, 0, 11);
    push_frame(7'h40, 7'h40, 7'h24, 3'b000, 0, 11);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) $display("FAIL coherent[%0d]: scoreboard empty", k);
      else begin
        e = sb_q.pop_front();
        if ({an, seg, dp, frame_done} !== e)
          $display("FAIL coherent[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                   k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        else n_pass++;
      end
      if (k == 17) bcd = 12'h200;
    end
  endtask

  // Digit C shows a dash; 20 disabled cycles mid-frame freeze the outputs.
  task automatic test_dash_pause;
    exp_t e;
    bcd = 12'h1C5;
    push_frame(7'h40, 7'h40, 7'h24, 3'b000, 0, 11);
    push_frame(7'h12, 7'h3F, 7'h79, 3'b000, 0, 6);
    for (int r = 0; r < 20; r++) push_frame(7'h12, 7'h3F, 7'h79, 3'b000, 6, 6);
    push_frame(7'h12, 7'h3F, 7'h79, 3'b000, 7, 11);
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) $display("FAIL pause[%0d]: scoreboard empty", k);
      else begin
        e = sb_q.pop_front();
        if ({an, seg, dp, frame_done} !== e)
          $display("FAIL pause[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                   k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        else n_pass++;
      end
      if (k == 17) clk_en = 1'b0;
      if (k == 37) clk_en = 1'b1;
    end
  endtask

  // Asynchronous reset in slot 2, then a restart from shadow zeros.
  task automatic test_async_reset;
    exp_t e;
    push_frame(7'h12, 7'h3F, 7'h79, 3'b000, 0, 9);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) $display("FAIL prerst[%0d]: scoreboard empty", k);
      else begin
        e = sb_q.pop_front();
        if ({an, seg, dp, frame_done} !== e)
          $display("FAIL prerst[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                   k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        else n_pass++;
      end
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, dp, frame_done} !== {3'b111, 7'h7F, 1'b1, 1'b0})
      $display("FAIL async_rst: got an=%b seg=%h dp=%b fd=%b, want an=111 seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp, frame_done} !== {3'b111, 7'h7F, 1'b1, 1'b0})
        $display("FAIL rst_hold[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=111 seg=7f dp=1 fd=0",
                 k, an, seg, dp, frame_done);
      else n_pass++;
    end
    sb_q.delete();
    #2 rst = 1'b1;
    push_frame(7'h40, 7'h7F, 7'h7F, 3'b000, 0, 11);
    push_frame(7'h12, 7'h3F, 7'h79, 3'b000, 0, 11);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (sb_q.size() == 0) $display("FAIL postrst[%0d]: scoreboard empty", k);
      else begin
        e = sb_q.pop_front();
        if ({an, seg, dp, frame_done} !== e)
          $display("FAIL postrst[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                   k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_scan();
    test_blanking();
    test_back_to_back();
    test_dash_pause();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
